// File: rtl/serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_adder : bit-serial WIDTH-bit unsigned adder, LSB first, one bit   |
// |                per clock through a half_adder-based full-adder slice.    |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    count;

  logic p_bit;
  logic g0_bit;
  logic g1_bit;
  logic s_bit;
  logic c_bit;

  // Full-adder slice: propagate/generate from the operands, then fold in carry.
  half_adder u_ha0 (.a(a_sr[0]), .b(b_sr[0]), .s(p_bit), .c(g0_bit));
  half_adder u_ha1 (.a(p_bit),   .b(carry),   .s(s_bit), .c(g1_bit));
  assign c_bit = g0_bit | g1_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            carry <= 1'b0;
            count <= '0;
          end
        end
        RUN: begin
          sum   <= {s_bit, sum[WIDTH-1:1]};
          carry <= c_bit;
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          count <= count + 1'b1;
          if (count == LAST) cout <= c_bit;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// Testbench for serial_adder: directed vector table at WIDTH=4 plus multi-cycle
// corner sequences, and a WIDTH=8 instance exercised with directed and random pairs.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start4, start8;
  logic [3:0] a4, b4, sum4;
  logic [7:0] a8, b8, sum8;
  logic       busy4, done4, cout4;
  logic       busy8, done8, cout8;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a_in(a4), .b_in(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a_in(a8), .b_in(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       c;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle4();
    int k = 0;
    while (busy4 && k < 30) begin tick(); k++; end
    if (busy4) chk("idle4_timeout", busy4, 0);
  endtask

  task automatic wait_idle8();
    int k = 0;
    while (busy8 && k < 30) begin tick(); k++; end
    if (busy8) chk("idle8_timeout", busy8, 0);
  endtask

  task automatic add4(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] es, input logic ec, input string tag);
    int n = 0;
    wait_idle4();
    a4 = a; b4 = b; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk({tag, "_busy"}, busy4, 1);
    while (!done4 && n < 20) begin tick(); n++; end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_sum"}, sum4, es);
    chk({tag, "_cout"}, cout4, ec);
  endtask

  task automatic add8(input logic [7:0] a, input logic [7:0] b, input string tag);
    int n = 0;
    logic [8:0] exp9;
    exp9 = {1'b0, a} + {1'b0, b};
    wait_idle8();
    a8 = a; b8 = b; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    while (!done8 && n < 30) begin tick(); n++; end
    chk({tag, "_latency"}, n, 8);
    chk({tag, "_result"}, {cout8, sum8}, exp9);
  endtask

  initial begin
    int n;
    int dones;
    int lows;
    int last_done;
    logic [3:0] s_at_done;

    vecs[0] = '{a: 4'd3,  b: 4'd5,  s: 4'd8,  c: 1'b0};
    vecs[1] = '{a: 4'd15, b: 4'd1,  s: 4'd0,  c: 1'b1};
    vecs[2] = '{a: 4'd15, b: 4'd15, s: 4'd14, c: 1'b1};
    vecs[3] = '{a: 4'd0,  b: 4'd0,  s: 4'd0,  c: 1'b0};
    vecs[4] = '{a: 4'd9,  b: 4'd6,  s: 4'd15, c: 1'b0};
    vecs[5] = '{a: 4'd10, b: 4'd7,  s: 4'd1,  c: 1'b1};
    vecs[6] = '{a: 4'd2,  b: 4'd2,  s: 4'd4,  c: 1'b0};
    vecs[7] = '{a: 4'd8,  b: 4'd8,  s: 4'd0,  c: 1'b1};

    reset = 1'b1; start4 = 1'b1; start8 = 1'b1;
    a4 = 4'd3; b4 = 4'd5; a8 = 8'd0; b8 = 8'd0;
    tick();
    tick();
    // start held with reset: must stay idle with everything cleared
    chk("reset_busy", busy4, 0);
    chk("reset_done", done4, 0);
    chk("reset_sum", sum4, 0);
    chk("reset_cout", cout4, 0);
    chk("reset_busy8", busy8, 0);
    start4 = 1'b0; start8 = 1'b0;
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++)
      add4(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, $sformatf("vec%0d", i));

    // start and operand changes during RUN are ignored
    wait_idle4();
    a4 = 4'd2; b4 = 4'd2; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd9;
    tick();
    start4 = 1'b0; a4 = 4'd12; b4 = 4'd3;
    dones = 0; s_at_done = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (done4) begin dones++; s_at_done = sum4; end
      tick();
    end
    chk("ignore_dones", dones, 1);
    chk("ignore_sum", s_at_done, 4);
    chk("ignore_cout", cout4, 0);
    chk("ignore_busy_end", busy4, 0);

    // reset at the second RUN edge aborts the add
    a4 = 4'd7; b4 = 4'd6; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", busy4, 0);
    chk("abort_sum", sum4, 0);
    chk("abort_cout", cout4, 0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done4) dones++;
      tick();
    end
    chk("abort_no_done", dones, 0);
    add4(4'd7, 4'd6, 4'd13, 1'b0, "after_abort");

    // start held high: back-to-back adds every WIDTH+2 cycles
    wait_idle4();
    a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
    dones = 0; lows = 0; last_done = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (!busy4) lows++;
      if (done4) begin
        if (dones > 0) chk($sformatf("b2b_period%0d", dones), i - last_done, 6);
        chk($sformatf("b2b_sum%0d", dones), sum4, 2);
        dones++;
        last_done = i;
      end
    end
    start4 = 1'b0;
    chk("b2b_dones", dones, 3);
    chk("b2b_busy_low", lows, 3);

    add8(8'd200, 8'd100, "w8_200_100");
    add8(8'd255, 8'd255, "w8_255_255");
    add8(8'd0,   8'd0,   "w8_0_0");
    add8(8'd128, 8'd127, "w8_128_127");
    add8(8'd85,  8'd170, "w8_85_170");
    add8(8'd1,   8'd255, "w8_1_255");
    for (int i = 0; i < 32; i++)
      add8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           $sformatf("w8_rand%0d", i));

    n = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
